ciq_dispatch: RTL and testbench

CIQ_DISPATCH -- requirements
Module: ciq_dispatch

---
 rtl/ciq_dispatch.sv | 151 +++++++++++++++
 tb/tb_ciq_dispatch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ciq_dispatch.sv
// Compacting-free issue queue with dispatch allocation, wakeup and grant handling.
// Entries are written to the lowest free slot, then woken, issued and freed in place.
module ciq_dispatch #(
  parameter int OPCODE_WIDTH = 7,
  parameter int PRF_WIDTH    = 6,
  parameter int AGE_WIDTH    = 5,
  parameter int IQ_DEPTH     = 16,
  parameter int IDX_WIDTH    = 4,
  parameter int WK_PORTS     = 4,
  localparam int IQ_WIDTH    = OPCODE_WIDTH + 3 * PRF_WIDTH + AGE_WIDTH + 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [OPCODE_WIDTH-1:0]           disp_op,
  input  logic [PRF_WIDTH-1:0]              disp_prs1,
  input  logic [PRF_WIDTH-1:0]              disp_prs2,
  input  logic                              disp_prs1_v,
  input  logic                              disp_prs2_v,
  input  logic                              disp_prs1_rdy,
  input  logic                              disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0]              disp_prd,
  input  logic                              disp_prd_v,
  input  logic [WK_PORTS-1:0]               wk_valid,
  input  logic [WK_PORTS*PRF_WIDTH-1:0]     wk_tag,
  input  logic [WK_PORTS-1:0]               iss_valid,
  input  logic [WK_PORTS*IDX_WIDTH-1:0]     iss_idx,
  output logic [IQ_DEPTH*IQ_WIDTH-1:0]      ciq,
  output logic [IDX_WIDTH:0]                free_cnt
);

  localparam int B_FREE = 0;
  localparam int B_ISS  = 1;
  localparam int B_AGE  = 2;
  localparam int B_PRDV = B_AGE + AGE_WIDTH;
  localparam int B_PRD  = B_PRDV + 1;
  localparam int B_S2R  = B_PRD + PRF_WIDTH;
  localparam int B_S2V  = B_S2R + 1;
  localparam int B_S2   = B_S2V + 1;
  localparam int B_S1R  = B_S2 + PRF_WIDTH;
  localparam int B_S1V  = B_S1R + 1;
  localparam int B_S1   = B_S1V + 1;
  localparam int B_OP   = B_S1 + PRF_WIDTH;

  localparam logic [IQ_WIDTH-1:0] FREE_ENT = IQ_WIDTH'(1);

  logic [IQ_WIDTH-1:0]  r_ent [IQ_DEPTH];
  logic [IQ_WIDTH-1:0]  w_nxt [IQ_DEPTH];
  logic [IQ_WIDTH-1:0]  w_new;
  logic [IQ_DEPTH-1:0]  w_free;
  logic [IQ_DEPTH-1:0]  w_grant;
  logic [IQ_DEPTH-1:0]  w_wk1;
  logic [IQ_DEPTH-1:0]  w_wk2;
  logic [IDX_WIDTH-1:0] w_alloc_idx;
  logic                 w_accept;
  logic                 w_new_wk1;
  logic                 w_new_wk2;
  logic [IDX_WIDTH:0]   w_cnt;

  genvar g;
  generate
    for (g = 0; g < IQ_DEPTH; g++) begin : g_out
      assign ciq[g*IQ_WIDTH +: IQ_WIDTH] = r_ent[g];
      assign w_free[g] = r_ent[g][B_FREE];
    end
  endgenerate

  // Readiness and counts come from registered state only; same-cycle releases do not count.
  assign disp_ready = |w_free;
  assign w_accept   = disp_valid & disp_ready & ~flush;
  assign free_cnt   = w_cnt;

  always_comb begin
    w_cnt       = '0;
    w_alloc_idx = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      w_cnt = w_cnt + (IDX_WIDTH + 1)'(w_free[i]);
    end
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (w_free[i]) w_alloc_idx = IDX_WIDTH'(i);
    end
  end

  // Wakeup matches ignore the prsN_v bits; grants are OR-merged across ports.
  always_comb begin
    w_wk1     = '0;
    w_wk2     = '0;
    w_grant   = '0;
    w_new_wk1 = 1'b0;
    w_new_wk2 = 1'b0;
    for (int k = 0; k < WK_PORTS; k++) begin
      if (wk_valid[k]) begin
        if (wk_tag[k*PRF_WIDTH +: PRF_WIDTH] == disp_prs1) w_new_wk1 = 1'b1;
        if (wk_tag[k*PRF_WIDTH +: PRF_WIDTH] == disp_prs2) w_new_wk2 = 1'b1;
      end
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (wk_valid[k] && wk_tag[k*PRF_WIDTH +: PRF_WIDTH] == r_ent[i][B_S1 +: PRF_WIDTH]) begin
          w_wk1[i] = 1'b1;
        end
        if (wk_valid[k] && wk_tag[k*PRF_WIDTH +: PRF_WIDTH] == r_ent[i][B_S2 +: PRF_WIDTH]) begin
          w_wk2[i] = 1'b1;
        end
        if (iss_valid[k] && iss_idx[k*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(i)) begin
          w_grant[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_new                         = '0;
    w_new[B_OP +: OPCODE_WIDTH]   = disp_op;
    w_new[B_S1 +: PRF_WIDTH]      = disp_prs1;
    w_new[B_S1V]                  = disp_prs1_v;
    w_new[B_S1R]                  = disp_prs1_rdy | w_new_wk1;
    w_new[B_S2 +: PRF_WIDTH]      = disp_prs2;
    w_new[B_S2V]                  = disp_prs2_v;
    w_new[B_S2R]                  = disp_prs2_rdy | w_new_wk2;
    w_new[B_PRD +: PRF_WIDTH]     = disp_prd;
    w_new[B_PRDV]                 = disp_prd_v;
  end

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      w_nxt[i] = r_ent[i];
      if (flush || r_ent[i][B_ISS]) begin
        w_nxt[i] = FREE_ENT;
      end else if (r_ent[i][B_FREE]) begin
        if (w_accept && w_alloc_idx == IDX_WIDTH'(i)) w_nxt[i] = w_new;
      end else begin
        if (w_accept && r_ent[i][B_AGE +: AGE_WIDTH] != '1) begin
          w_nxt[i][B_AGE +: AGE_WIDTH] = r_ent[i][B_AGE +: AGE_WIDTH] + 1'b1;
        end
        if (w_wk1[i])   w_nxt[i][B_S1R] = 1'b1;
        if (w_wk2[i])   w_nxt[i][B_S2R] = 1'b1;
        if (w_grant[i]) w_nxt[i][B_ISS] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IQ_DEPTH; i++) r_ent[i] <= FREE_ENT;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) r_ent[i] <= w_nxt[i];
    end
  end

endmodule

// File: tb/tb_ciq_dispatch.sv
// Directed self-checking bench for ciq_dispatch at default parameters.
module tb_ciq_dispatch;

  localparam int W = 37;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          disp_valid;
  logic          disp_ready;
  logic [6:0]    disp_op;
  logic [5:0]    disp_prs1, disp_prs2, disp_prd;
  logic          disp_prs1_v, disp_prs2_v, disp_prs1_rdy, disp_prs2_rdy, disp_prd_v;
  logic [3:0]    wk_valid;
  logic [23:0]   wk_tag;
  logic [3:0]    iss_valid;
  logic [15:0]   iss_idx;
  logic [D*W-1:0] ciq;
  logic [4:0]    free_cnt;

  int n_total = 0;
  int n_pass  = 0;
  logic [D*W-1:0] all_free;
  logic [D*W-1:0] saved;

  ciq_dispatch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_prs1_v(disp_prs1_v), .disp_prs2_v(disp_prs2_v),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .disp_prd(disp_prd), .disp_prd_v(disp_prd_v),
    .wk_valid(wk_valid), .wk_tag(wk_tag),
    .iss_valid(iss_valid), .iss_idx(iss_idx),
    .ciq(ciq), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent(input int i);
    return ciq[i*W +: W];
  endfunction

  function automatic logic [W-1:0] mk(input logic [6:0] op, input logic [5:0] p1,
                                      input logic v1, input logic r1, input logic [5:0] p2,
                                      input logic v2, input logic r2, input logic [5:0] prd,
                                      input logic prdv, input logic [4:0] age,
                                      input logic iss, input logic fr);
    return {op, p1, v1, r1, p2, v2, r2, prd, prdv, age, iss, fr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag, input logic [D*W-1:0] exp);
    n_total++;
    assert (ciq === exp) n_pass++;
    else $error("FAIL %s: ciq observed %0h expected %0h", tag, ciq, exp);
  endtask

  task automatic disp(input logic [6:0] op, input logic [5:0] p1, input logic v1,
                      input logic r1, input logic [5:0] p2, input logic v2, input logic r2,
                      input logic [5:0] prd, input logic prdv);
    disp_valid = 1'b1; disp_op = op;
    disp_prs1 = p1; disp_prs1_v = v1; disp_prs1_rdy = r1;
    disp_prs2 = p2; disp_prs2_v = v2; disp_prs2_rdy = r2;
    disp_prd = prd; disp_prd_v = prdv;
  endtask

  task automatic idle();
    disp_valid = 1'b0; flush = 1'b0; wk_valid = '0; wk_tag = '0;
    iss_valid = '0; iss_idx = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    all_free = {D{37'd1}};
    rst_n = 1'b0;
    idle();
    disp(7'h0, 6'h0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 6'h0, 1'b0);
    disp_valid = 1'b0;

    #12;
    chk_q("reset_ciq", all_free);
    chk("reset_free_cnt", 64'(free_cnt), 64'd16);
    chk("reset_ready", 64'(disp_ready), 64'd1);

    @(negedge clk);
    rst_n = 1'b1;
    disp(7'h33, 6'd5, 1'b1, 1'b0, 6'd6, 1'b1, 1'b1, 6'd9, 1'b1);
    step();
    idle();
    chk("first_entry0", 64'(ent(0)), 64'(mk(7'h33, 5, 1, 0, 6, 1, 1, 9, 1, 0, 0, 0)));
    chk("first_free_cnt", 64'(free_cnt), 64'd15);

    // Non-matching wakeup then a matching one on port 2.
    wk_valid = 4'b0100; wk_tag = 24'(7) << 12;
    step();
    idle();
    chk("wake_miss", 64'(ent(0)), 64'(mk(7'h33, 5, 1, 0, 6, 1, 1, 9, 1, 0, 0, 0)));
    wk_valid = 4'b0100; wk_tag = 24'(5) << 12;
    step();
    idle();
    chk("wake_hit", 64'(ent(0)), 64'(mk(7'h33, 5, 1, 1, 6, 1, 1, 9, 1, 0, 0, 0)));

    // Same-cycle bypass on port 0.
    disp(7'h40, 6'd12, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd10, 1'b1);
    wk_valid = 4'b0001; wk_tag = 24'd12;
    step();
    idle();
    chk("bypass_entry1", 64'(ent(1)), 64'(mk(7'h40, 12, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0)));
    chk("age_entry0", 64'(ent(0)[6:2]), 64'd1);

    for (int i = 2; i < D; i++) begin
      disp(7'(i), 6'(20 + i), 1'b1, 1'b0, 6'(40 + i), 1'b1, 1'b0, 6'(i), 1'b1);
      step();
    end
    idle();
    chk("full_ready", 64'(disp_ready), 64'd0);
    chk("full_free_cnt", 64'(free_cnt), 64'd0);
    chk("full_age0", 64'(ent(0)[6:2]), 64'd15);
    chk("full_age1", 64'(ent(1)[6:2]), 64'd14);
    chk("full_entry15", 64'(ent(15)), 64'(mk(7'd15, 35, 1, 0, 55, 1, 0, 15, 1, 0, 0, 0)));

    saved = ciq;
    disp(7'h7f, 6'd1, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 6'd3, 1'b1);
    step();
    idle();
    chk_q("full_no_write", saved);

    // Duplicate grants to entry 3 from ports 0 and 1.
    iss_valid = 4'b0011; iss_idx = 16'h0033;
    step();
    idle();
    chk("grant_issued", 64'(ent(3)[1:0]), 64'b10);
    chk("grant_ready", 64'(disp_ready), 64'd0);
    disp(7'h55, 6'd7, 1'b1, 1'b0, 6'd8, 1'b0, 1'b1, 6'd11, 1'b1);
    step();
    chk("release_entry3", 64'(ent(3)), 64'd1);
    chk("release_free_cnt", 64'(free_cnt), 64'd1);
    chk("release_ready", 64'(disp_ready), 64'd1);
    step();
    idle();
    chk("refill_entry3", 64'(ent(3)), 64'(mk(7'h55, 7, 1, 0, 8, 0, 1, 11, 1, 0, 0, 0)));
    chk("refill_age0", 64'(ent(0)[6:2]), 64'd16);
    chk("refill_free_cnt", 64'(free_cnt), 64'd0);

    disp(7'h22, 6'd1, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 6'd3, 1'b1);
    wk_valid = 4'hf; wk_tag = {6'd35, 6'd34, 6'd33, 6'd32};
    iss_valid = 4'hf; iss_idx = 16'h3210;
    flush = 1'b1;
    step();
    idle();
    chk_q("flush_ciq", all_free);
    chk("flush_free_cnt", 64'(free_cnt), 64'd16);
    chk("flush_ready", 64'(disp_ready), 64'd1);

    disp(7'h01, 6'd1, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 6'd3, 1'b1);
    step();
    step();
    iss_valid = 4'b1000; iss_idx = 16'h1000;
    chk("pre_reset_free_cnt", 64'(free_cnt), 64'd14);
    #2;
    rst_n = 1'b0;
    #1;
    chk_q("async_reset_ciq", all_free);
    chk("async_reset_free_cnt", 64'(free_cnt), 64'd16);
    chk("async_reset_ready", 64'(disp_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    disp(7'h11, 6'd4, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    step();
    idle();
    chk("post_reset_entry0", 64'(ent(0)), 64'(mk(7'h11, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("post_reset_entry1", 64'(ent(1)), 64'd1);
    chk("post_reset_free_cnt", 64'(free_cnt), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
